// File: rtl/bootloader_supervisor_pkg.sv
// Shared definitions for the bootloader supervisor: LED mode encodings
// and the microsecond-per-millisecond ratio used by the tick generator.
package bootloader_supervisor_pkg;

    typedef enum logic [1:0] {
        LED_OFF     = 2'd0,
        LED_ON      = 2'd1,
        LED_BREATHE = 2'd2,
        LED_BLINK   = 2'd3
    } led_mode_e;

    localparam int US_PER_MS = 1000;

endpackage

// File: rtl/supervisor_tick_gen.sv
// Exact microsecond and millisecond tick generator. Both ticks are
// single-cycle pulses decoded from the counter state, so ms_tick is
// coincident with the us_tick on which the microsecond count wraps.
module supervisor_tick_gen
    import bootloader_supervisor_pkg::*;
#(
    parameter int CLK_HZ = 48000000
) (
    input  logic clk,
    input  logic reset_n,
    output logic us_tick,
    output logic ms_tick
);

    localparam int CYC_PER_US = CLK_HZ / 1000000;
    localparam int CW         = (CYC_PER_US > 1) ? $clog2(CYC_PER_US) : 1;
    localparam int UW         = $clog2(US_PER_MS);

    logic [CW-1:0] r_cyc_cnt;
    logic [UW-1:0] r_us_cnt;

    assign us_tick = (r_cyc_cnt == CW'(CYC_PER_US - 1));
    assign ms_tick = us_tick && (r_us_cnt == UW'(US_PER_MS - 1));

    // Clock-cycle counter, wraps every microsecond.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)     r_cyc_cnt <= '0;
        else if (us_tick) r_cyc_cnt <= '0;
        else              r_cyc_cnt <= r_cyc_cnt + CW'(1);
    end

    // Microsecond counter, wraps every millisecond.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)     r_us_cnt <= '0;
        else if (ms_tick) r_us_cnt <= '0;
        else if (us_tick) r_us_cnt <= r_us_cnt + UW'(1);
    end

endmodule

// File: rtl/bootloader_supervisor.sv
// Bootloader supervisor: time base, shared breathe/blink generators,
// per-channel LED PWM, host-presence watchdog and warm-boot request.
module bootloader_supervisor
    import bootloader_supervisor_pkg::*;
#(
    parameter int CLK_HZ     = 48000000,
    parameter int NUM_LEDS   = 2,
    parameter int PWM_BITS   = 8,
    parameter int TIMEOUT_MS = 1000,
    parameter int BLINK_MS   = 250
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [2*NUM_LEDS-1:0] led_mode,
    input  logic                  sof_valid,
    input  logic                  boot_req,
    output logic [NUM_LEDS-1:0]   led,
    output logic                  host_present,
    output logic                  timeout,
    output logic                  boot
);

    localparam logic [PWM_BITS-1:0] LEVEL_MAX = '1;
    localparam int AW = $clog2(TIMEOUT_MS + 1);
    localparam int BW = (BLINK_MS > 1) ? $clog2(BLINK_MS) : 1;

    logic                w_us_tick;
    logic                w_ms_tick;
    logic [PWM_BITS-1:0] r_level;
    logic                r_dir_down;
    logic [BW-1:0]       r_blink_cnt;
    logic                r_blink_phase;
    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic [NUM_LEDS-1:0] w_led_next;
    logic [NUM_LEDS-1:0] r_led;
    logic [AW-1:0]       r_absent_ms;
    logic                r_timeout;
    logic                r_host_present;
    logic                r_boot_latched;
    logic                r_boot;

    supervisor_tick_gen #(
        .CLK_HZ (CLK_HZ)
    ) u_tick_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .us_tick (w_us_tick),
        .ms_tick (w_ms_tick)
    );

    // Shared breathe ramp: triangle wave, holding one ms at each extreme.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_level    <= '0;
            r_dir_down <= 1'b0;
        end else if (w_ms_tick) begin
            if (!r_dir_down) begin
                if (r_level == LEVEL_MAX) r_dir_down <= 1'b1;
                else                      r_level    <= r_level + PWM_BITS'(1);
            end else begin
                if (r_level == '0) r_dir_down <= 1'b0;
                else               r_level    <= r_level - PWM_BITS'(1);
            end
        end
    end

    // Shared blink phase: toggles every BLINK_MS milliseconds.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (w_ms_tick) begin
            if (r_blink_cnt == BW'(BLINK_MS - 1)) begin
                r_blink_cnt   <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + BW'(1);
            end
        end
    end

    // Free-running PWM ramp compared against the breathe level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_pwm_cnt <= '0;
        else          r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
    end

    for (genvar gi = 0; gi < NUM_LEDS; gi++) begin : g_led
        led_mode_e w_mode;
        logic      w_target;

        assign w_mode = led_mode_e'(led_mode[2*gi +: 2]);

        // Per-channel mode mux.
        // NOTE: w_target gets a default before the case so no path leaves it
        // unassigned, which would otherwise infer a latch.
        always_comb begin
            w_target = 1'b0;
            case (w_mode)
                LED_OFF:     w_target = 1'b0;
                LED_ON:      w_target = 1'b1;
                LED_BREATHE: w_target = (r_level > r_pwm_cnt);
                LED_BLINK:   w_target = r_blink_phase;
                default:     w_target = 1'b0;
            endcase
        end

        assign w_led_next[gi] = w_target;
    end

    // LED output register: one clock from mode change to pin.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_led <= '0;
        else          r_led <= w_led_next;
    end

    // Host watchdog: SOF restarts the absence count and wins over a
    // coincident ms tick; the count saturates at TIMEOUT_MS.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_absent_ms    <= '0;
            r_timeout      <= 1'b0;
            r_host_present <= 1'b0;
        end else if (sof_valid) begin
            r_absent_ms    <= '0;
            r_timeout      <= 1'b0;
            r_host_present <= 1'b1;
        end else begin
            if (w_ms_tick && (r_absent_ms < AW'(TIMEOUT_MS)))
                r_absent_ms <= r_absent_ms + AW'(1);
            if (r_absent_ms == AW'(TIMEOUT_MS)) begin
                r_timeout      <= 1'b1;
                r_host_present <= 1'b0;
            end
        end
    end

    // Sticky boot request and registered boot output.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_boot_latched <= 1'b0;
            r_boot         <= 1'b0;
        end else begin
            r_boot_latched <= r_boot_latched | boot_req;
            r_boot         <= r_timeout | r_boot_latched;
        end
    end

    assign led          = r_led;
    assign host_present = r_host_present;
    assign timeout      = r_timeout;
    assign boot         = r_boot;

endmodule

// File: tb/tb_bootloader_supervisor.sv
// Self-checking bench for bootloader_supervisor: a mode-mux vector table,
// then a long randomized run checked every cycle against a closed-form
// reference model, with targeted checks for the watchdog corner cases.
module tb_bootloader_supervisor;

    localparam int CLK_HZ     = 2000000;
    localparam int NUM_LEDS   = 2;
    localparam int PWM_BITS   = 4;
    localparam int TIMEOUT_MS = 5;
    localparam int BLINK_MS   = 3;

    localparam int CYC_PER_US = CLK_HZ / 1000000;
    localparam int CYC_PER_MS = CLK_HZ / 1000;
    localparam int MAXV       = (1 << PWM_BITS) - 1;
    localparam int RUN_CYCLES = 34 * CYC_PER_MS;

    logic                  clk = 1'b0;
    logic                  reset_n = 1'b0;
    logic [2*NUM_LEDS-1:0] led_mode = '0;
    logic                  sof_valid = 1'b0;
    logic                  boot_req = 1'b0;
    logic [NUM_LEDS-1:0]   led;
    logic                  host_present;
    logic                  timeout;
    logic                  boot;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bootloader_supervisor #(
        .CLK_HZ     (CLK_HZ),
        .NUM_LEDS   (NUM_LEDS),
        .PWM_BITS   (PWM_BITS),
        .TIMEOUT_MS (TIMEOUT_MS),
        .BLINK_MS   (BLINK_MS)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .led_mode     (led_mode),
        .sof_valid    (sof_valid),
        .boot_req     (boot_req),
        .led          (led),
        .host_present (host_present),
        .timeout      (timeout),
        .boot         (boot)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Breathe level after n ms ticks: triangle of period 2*(MAX+1).
    function automatic int ref_level(input int n);
        int p;
        p = n % (2 * (MAXV + 1));
        return (p <= MAXV) ? p : (2 * MAXV + 1 - p);
    endfunction

    // Expected LED value registered at an edge preceded by k clock cycles.
    function automatic logic ref_led(input logic [1:0] mode, input int k);
        int n;
        n = k / CYC_PER_MS;
        case (mode)
            2'd0:    return 1'b0;
            2'd1:    return 1'b1;
            2'd2:    return ref_level(n) > (k % (MAXV + 1));
            default: return ((n / BLINK_MS) % 2) == 1;
        endcase
    endfunction

    typedef struct packed {
        logic [3:0] mode;
        logic [1:0] exp_led;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int   ms_idx;
        int   mode_rand;
        int   m_since;
        logic m_timeout, m_host, m_boot, m_latched;
        logic [NUM_LEDS-1:0] m_led;
        int   first_sof;
        int   prio_edge;
        int   duty_hi;

        // Generators sit at level 0 / phase 0 for the first ms after reset.
        vecs[0] = '{4'b0111, 2'b10};
        vecs[1] = '{4'b1101, 2'b01};
        vecs[2] = '{4'b0101, 2'b11};
        vecs[3] = '{4'b0000, 2'b00};
        vecs[4] = '{4'b1010, 2'b00};
        vecs[5] = '{4'b0110, 2'b10};
        vecs[6] = '{4'b1111, 2'b00};
        vecs[7] = '{4'b1001, 2'b01};

        // Reset held: outputs and ticks stay low whatever the inputs do.
        for (int i = 0; i < 3; i++) begin
            led_mode  = 4'($urandom_range(0, 15));
            sof_valid = 1'($urandom_range(0, 1));
            boot_req  = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("reset_outputs", {led, host_present, timeout, boot}, 0);
            check("reset_ticks", {dut.w_us_tick, dut.w_ms_tick}, 0);
        end
        sof_valid = 1'b0;
        boot_req  = 1'b0;
        reset_n   = 1'b1;

        // Mode mux table, one vector per clock.
        for (int i = 0; i < 8; i++) begin
            led_mode = vecs[i].mode;
            @(negedge clk);
            check("table_led", led, vecs[i].exp_led);
        end

        reset_n  = 1'b0;
        led_mode = '0;
        @(negedge clk);
        reset_n = 1'b1;

        m_since   = 0;
        m_timeout = 1'b0;
        m_host    = 1'b0;
        m_boot    = 1'b0;
        m_latched = 1'b0;
        m_led     = '0;
        mode_rand = 0;
        first_sof = -1;
        prio_edge = -1;
        duty_hi   = 0;

        for (int e = 1; e <= RUN_CYCLES; e++) begin
            ms_idx = (e - 1) / CYC_PER_MS;
            if ((e - 1) % 700 == 0) mode_rand = $urandom_range(0, 15);
            led_mode = (e >= 15990 && e <= 18010) ? 4'b1010 : 4'(mode_rand);

            sof_valid = 1'b0;
            if (ms_idx >= 7 && ms_idx < 12 && $urandom_range(0, 1499) == 0) sof_valid = 1'b1;
            if (ms_idx >= 20 && $urandom_range(0, 499) == 0) sof_valid = 1'b1;
            if (e == 23000) sof_valid = 1'b1;
            if ((e % CYC_PER_MS == 0) && (m_since == TIMEOUT_MS - 1) &&
                ms_idx >= 13 && ms_idx < 19) begin
                sof_valid = 1'b1;
                prio_edge = e;
            end
            if (sof_valid && first_sof < 0) first_sof = e;
            boot_req = (e == 56001);

            @(posedge clk);
            for (int ch = 0; ch < NUM_LEDS; ch++)
                m_led[ch] = ref_led(led_mode[2*ch +: 2], e - 1);
            m_boot = m_timeout | m_latched;
            if (sof_valid) begin
                m_timeout = 1'b0;
                m_host    = 1'b1;
            end else if (m_since >= TIMEOUT_MS) begin
                m_timeout = 1'b1;
                m_host    = 1'b0;
            end
            m_latched = m_latched | boot_req;
            m_since   = sof_valid ? 0 : m_since + ((e % CYC_PER_MS == 0) ? 1 : 0);

            @(negedge clk);
            check("outputs", {led, host_present, timeout, boot},
                  {m_led, m_host, m_timeout, m_boot});
            check("ticks", {dut.w_us_tick, dut.w_ms_tick},
                  {(e % CYC_PER_US) == CYC_PER_US - 1, (e % CYC_PER_MS) == CYC_PER_MS - 1});

            if (e >= 16001 && e <= 16016) duty_hi += int'(led[0]);
            if (e == 16016) check("breathe_duty_level8", duty_hi, 8);
            if (e == 10000) check("timeout_before", timeout, 0);
            if (e == 10001) check("timeout_rise", timeout, 1);
            if (e == 10002) check("boot_from_timeout", boot, 1);
            if (e == first_sof) check("sof_clears", {host_present, timeout}, 2'b10);
            if (e == first_sof + 1) check("boot_after_sof", boot, 0);
            if (e == prio_edge) check("prio_absent", dut.r_absent_ms, 0);
            if (e == prio_edge) check("prio_timeout", timeout, 0);
            if (e == 56002) check("boot_req_boot", boot, 1);
            if (e == RUN_CYCLES) check("boot_sticky", boot, 1);
        end

        // Asynchronous reset in the middle of a clock period.
        sof_valid = 1'b0;
        boot_req  = 1'b0;
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset", {led, host_present, timeout, boot}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bootloader_supervisor.md
Name: bootloader_supervisor

Overview:
Parametrised supervisor for the bootloader top level. It generates exact microsecond and millisecond ticks from a configurable clock, and drives NUM_LEDS indicator outputs, each with a selectable mode: off, on, breathe or blink. It also runs the host-presence watchdog from SOF pulses and produces the boot request to the FPGA warm-boot primitive. It sits beside usb_fs_pe and takes sof_valid from it.

Parameters:
CLK_HZ, 48000000, input clock frequency; must be a multiple of 1000000.
NUM_LEDS, 2, number of indicator outputs (1..8).
PWM_BITS, 8, PWM and brightness resolution.
TIMEOUT_MS, 1000, host-absence time before boot asserts (1..65535).
BLINK_MS, 250, blink half-period in ms (1..1023).

Ports:
clk  in  1  system clock at CLK_HZ.
reset_n  in  1  asynchronous reset, active low.
led_mode  in  2*NUM_LEDS  per-channel mode; channel i uses bits [2i+1:2i]. Encoding: 0 off, 1 on, 2 breathe, 3 blink.
sof_valid  in  1  single-cycle pulse per received SOF.
boot_req  in  1  pulse from usb_spi_bridge_ep requesting a user-design boot.
led  out  NUM_LEDS  registered PWM outputs.
host_present  out  1  high once an SOF has been seen and timeout has not expired.
timeout  out  1  host-absence timeout flag.
boot  out  1  timeout OR latched boot_req.

Behaviour:
- Reset: all counters and flags are 0. led=0, host_present=0, timeout=0, boot=0. Breathe level=0 with direction up; blink phase=0.
- us tick: the cycle counter runs 0..CLK_HZ/1e6-1, and us_tick is a one-cycle pulse on wrap. At 48 MHz this gives exactly one tick per 48 cycles; there is no off-by-one stretch.
- ms tick: counts us ticks 0..999, and ms_tick pulses on the cycle the us count wraps, coincident with us_tick.
- Breathe generator, shared by all channels so breathing LEDs stay in phase. It updates on ms_tick only:
  - up and level<MAX: level+1.
  - up and level==MAX: direction<=down, level held.
  - down and level>0: level-1.
  - down and level==0: direction<=up, level held.
  - MAX=2^PWM_BITS-1. Full period is 2*(MAX+1) ms, i.e. 512 ms at PWM_BITS=8.
- Blink generator: ms counter 0..BLINK_MS-1; the phase toggles on wrap. Shared by all channels.
- PWM counter: PWM_BITS wide, free-running, +1 every clk, wraps naturally.
- Per-channel target (combinational):
  - off: 0.
  - on: 1.
  - breathe: (level > pwm_cnt).
  - blink: phase.
  - led[i] is that value registered, so latency is 1 clk from a mode change.
- Mode changes take effect on the next clk and do not disturb the shared generators.
- Host watchdog:
  - absent_ms is a saturating counter, width $clog2(TIMEOUT_MS+1).
  - sof_valid: absent_ms<=0, timeout<=0, host_present<=1. This has priority over a coincident ms_tick.
  - Otherwise on ms_tick: if absent_ms<TIMEOUT_MS then increment, else hold.
  - When absent_ms==TIMEOUT_MS (registered compare): timeout<=1, host_present<=0.
  - timeout remains 1 until the next sof_valid.
  - Before any SOF, the counter still runs, so timeout asserts TIMEOUT_MS ms after reset. This matches the boot-if-no-host requirement.
- boot_req latch: sticky once set; cleared only by reset_n. It is not cleared by SOF.
- boot = timeout | boot_latched, registered, 1-clk latency.
- Reset mid-operation: all state is cleared asynchronously; outputs drop low immediately.

Decomposition:
- Package bootloader_supervisor_pkg: the led mode encodings (LED_OFF, LED_ON, LED_BREATHE, LED_BLINK) and the constant US_PER_MS=1000.
- Sub-module supervisor_tick_gen, parameter CLK_HZ, outputs us_tick and ms_tick; it is reusable by other timeouts in the design.
- PWM compare and mode mux are a generate loop over NUM_LEDS in the top module.

Test Plan:
- Reset and ticks, with CLK_HZ=2000000: hold reset_n=0 → all outputs 0. Release → us_tick every 2 clk, ms_tick every 2000 clk; first ms_tick at clk 2000.
- Breathe, with PWM_BITS=4, mode=2: level reads 0,1..15,15,14..0,0,1 on successive ms ticks. In the ms where level=8, the led duty is exactly 8/16 over 16 clk.
- Mode mux, with NUM_LEDS=2: led_mode=0b0111 (ch0 blink, ch1 on) with BLINK_MS=3 → led[1]=1 constant; led[0] toggles every 3 ms. Write mode 0 → led all 0 one clk later.
- Watchdog, with TIMEOUT_MS=5: no SOF → timeout and boot rise after the 5th ms tick plus 1 clk. Pulse sof_valid → timeout=0 and host_present=1 next clk, boot=0 the clk after.
- Priority: pulse sof_valid on the same clk as the ms_tick that would reach TIMEOUT_MS → counter=0 and no timeout.
- boot_req: pulse boot_req for 1 clk → boot=1 within 2 clk and stays high through later SOFs. Assert reset_n=0 mid-run → boot=0 asynchronously.
